// File: rtl/multi_digit_seg_bank.sv
// multi_digit_seg_bank: N-digit BCD register bank with debounced-strobe writes
// (addressed or shift-in), clear, leading-zero blanking and registered 7-segment decode.
module multi_digit_seg_bank #(
    parameter int N_DIGITS = 4,
    parameter int AW       = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_ni,
    input  logic                  mode_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [3:0]            bcd_i,
    input  logic                  clr_i,
    input  logic                  lzb_i,
    output logic [7*N_DIGITS-1:0] seg_o,
    output logic                  ack_o,
    output logic                  err_o
);
    logic                       s1_q, s2_q, h_q, armed_q, strobe, lead;
    logic [1:0]                 vld_q;
    logic [N_DIGITS-1:0][3:0]   dig_q, dig_d;
    logic [7*N_DIGITS-1:0]      seg_q, seg_d;
    logic                       ack_q, ack_d, err_q, err_d;
    logic [3:0]                 shown;

    function automatic logic [6:0] dec(input logic [3:0] b);
        case (b)
            4'd0:    dec = ~7'b1111110;
            4'd1:    dec = ~7'b0110000;
            4'd2:    dec = ~7'b1101101;
            4'd3:    dec = ~7'b1111001;
            4'd4:    dec = ~7'b0110011;
            4'd5:    dec = ~7'b1011011;
            4'd6:    dec = ~7'b1011111;
            4'd7:    dec = ~7'b1110000;
            4'd8:    dec = ~7'b1111111;
            4'd9:    dec = ~7'b1111011;
            default: dec = 7'h7F;
        endcase
    endfunction

    // armed_q stays low after reset until the synchronised button has really been seen
    // released, so a press held through reset never produces a write.
    assign strobe = armed_q & h_q & ~s2_q;

    always_comb begin
        dig_d = dig_q;
        ack_d = 1'b0;
        err_d = 1'b0;
        if (clr_i) begin
            dig_d = '1;
        end else if (strobe && mode_i) begin
            dig_d = {dig_q[N_DIGITS-2:0], bcd_i};
            ack_d = 1'b1;
        end else if (strobe && int'(addr_i) < N_DIGITS) begin
            dig_d[addr_i] = bcd_i;
            ack_d = 1'b1;
        end else if (strobe) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        seg_d = '1;
        lead  = lzb_i;
        shown = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (dig_q[i] inside {[4'd1:4'd9]}) lead = 1'b0;
            shown = (lead && i != 0) ? 4'hF : dig_q[i];
            seg_d[7*i +: 7] = dec(shown);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            h_q     <= 1'b1;
            vld_q   <= '0;
            armed_q <= 1'b0;
            dig_q   <= '1;
            seg_q   <= '1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s1_q    <= wr_ni;
            s2_q    <= s1_q;
            h_q     <= s2_q;
            vld_q   <= {vld_q[0], 1'b1};
            armed_q <= armed_q | (vld_q[1] & s2_q);
            dig_q   <= dig_d;
            seg_q   <= seg_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign seg_o = seg_q;
    assign ack_o = ack_q;
    assign err_o = err_q;
endmodule

// File: doc/multi_digit_seg_bank.md
Name: multi_digit_seg_bank

Overview:
- Parametrised bank of N_DIGITS BCD digit registers, each driving one negative-logic 7-segment display.
- Written from a raw active-low pushbutton strobe (WRn), which is synchronised and edge-detected internally to exactly one write per press.
- Supports addressed write, shift-in (scroll) write, synchronous clear and leading-zero blanking.
- Sits between the board switches/pushbuttons and the 7-segment display pins; generalises the two-digit latched BCD display.

Parameters:
- N_DIGITS, 4, number of digit registers/displays; legal range 2..8.
- AW, 2, width of ADDR; 2**AW >= N_DIGITS is required.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RSTn  input  1  asynchronous active-low reset.
- WRn  input  1  raw active-low write pushbutton, asynchronous to CLK.
- MODE  input  1  0 = addressed write, 1 = shift-in write.
- ADDR  input  AW  target digit index for addressed write.
- BCD  input  4  data to write.
- CLR  input  1  synchronous clear of all digits, level-sensitive.
- LZB  input  1  leading-zero blanking enable.
- SEG  output  7*N_DIGITS  segment drive, active low. Digit i uses SEG[7i+6:7i]; bit 7i+6 = segment a … bit 7i = segment g.
- ACK  output  1  one-cycle pulse: write accepted.
- ERR  output  1  one-cycle pulse: addressed write rejected (ADDR >= N_DIGITS).

Behaviour:
- Reset (RSTn low, asynchronous):
  - all digit registers = 4'hF (blank code); SEG = all ones (every display dark);
  - ACK = 0, ERR = 0;
  - both synchroniser flops and the edge-history flop = 1 (button released).
  - Reset mid-press discards any in-flight strobe: no write and no ACK after release, even if WRn is still low.
- Synchroniser: 2-flop chain on WRn (s1, s2), plus history flop h <= s2.
  - strobe = h & ~s2, high for exactly one cycle per falling edge of the synchronised WRn.
  - Holding WRn low gives one strobe only; WRn must return high (synchronised) before the next strobe.
- Timing from the first rising edge E1 that samples WRn low:
  - E2: s2 = 0, strobe high during E2..E3.
  - E3: digit write, ACK/ERR registered high for cycle E3..E4.
  - E4: SEG reflects new digit values (decode stage is registered).
  - Total: 3 cycles WRn-sample to register update, 4 cycles to display.
- Write on strobe, priority CLR > write:
  - CLR = 1 at the edge: all digits <= 4'hF; the strobe is consumed; ACK = 0, ERR = 0.
  - MODE = 0, ADDR < N_DIGITS: digit[ADDR] <= BCD; ACK pulses.
  - MODE = 0, ADDR >= N_DIGITS: no digit changes; ERR pulses, ACK stays 0.
  - MODE = 1: digit[i] <= digit[i-1] for i = N_DIGITS-1..1, digit[0] <= BCD; ADDR is ignored; ACK pulses. The top digit falls off; there is no wrap-around.
- CLR with no strobe still clears at the edge; no ACK.
- BCD values 10..15 are stored as given and displayed blank.
- Decode per digit (active low, bit order a..g), for codes 0..9:
  - 0 = ~1111110, 1 = ~0110000, 2 = ~1101101, 3 = ~1111001, 4 = ~0110011;
  - 5 = ~1011011, 6 = ~1011111, 7 = ~1110000, 8 = ~1111111, 9 = ~1111011;
  - any other code = 1111111.
- Leading-zero blanking (LZB = 1):
  - Scanning from digit N_DIGITS-1 downward, each digit holding 0 or a blank code is blanked until the first digit holding 1..9.
  - Digit 0 is never blanked when it holds 0.
  - LZB only affects the decode stage, not the stored values. A change takes effect on SEG one edge later.
- ACK and ERR are never high together and never high for more than one cycle per press.

Test Plan:
- Reset: assert RSTn = 0 mid-simulation -> SEG = all ones (28'hFFFFFFF for N_DIGITS = 4), ACK = 0, ERR = 0 immediately, without waiting for a CLK edge.
- Addressed write: MODE = 0, ADDR = 2, BCD = 7, WRn low for 6 cycles -> exactly one ACK pulse 3 edges after first low sample; SEG[20:14] = 7'b0001111 one edge later; other digits stay 1111111.
- Shift mode: MODE = 1, three presses with BCD = 1, 2, 3 -> digits[3:0] = F,1,2,3; SEG shows blank,1,2,3; a fourth press with BCD = 4 gives 1,2,3,4; a fifth with BCD = 5 gives 2,3,4,5 (the 1 is dropped).
- LZB: digits[3:0] = 0,0,4,0 -> with LZB = 1, digits 3 and 2 are blank, digit 1 shows 4, digit 0 shows 0; toggle LZB = 0 -> all four displayed one edge later.
- Range error: N_DIGITS = 3, AW = 2, ADDR = 3, one press -> ERR pulses once, ACK stays 0, SEG unchanged.
- Priority and reset: CLR = 1 held in the strobe cycle -> all digits blank, no ACK. Separately, pulse RSTn low between E1 and E3 of a press while WRn stays low -> no write and no ACK after release.
